tpu_seq: RTL and testbench

TPU_SEQ -- requirements
Module: tpu_seq

---
 rtl/tpu_pkg.sv | 16 +
 rtl/tpu_skew_decode.sv | 18 +
 rtl/tpu_seq.sv | 95 +++++++++
 tb/tb_tpu_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: array/operand defaults and the sequencer state type.
package tpu_pkg;

    localparam int unsigned DIM     = 8;
    localparam int unsigned BITS_AB = 8;
    localparam int unsigned BITS_C  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCompute,
        StDrain,
        StDone
    } tpu_seq_state_t;

endpackage

// File: rtl/tpu_skew_decode.sv
// Skewed feed-window decode: lane i is fed while i <= k_idx <= i+DIM-1.
module tpu_skew_decode #(
    parameter int unsigned DIM = 8,
    parameter int unsigned KW  = 5
) (
    input  logic [KW-1:0]  k_idx,
    input  logic           active,
    output logic [DIM-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(DIM); i++) begin
            mask[i] = active && (int'(k_idx) >= i) && (int'(k_idx) <= i + int'(DIM) - 1);
        end
    end

endmodule

// File: rtl/tpu_seq.sv
// Systolic matmul sequencer: clears accumulators, feeds 3*DIM-2 skewed
// k-steps (frozen by stall), then drains DIM result rows under rd_ready.
module tpu_seq #(
    parameter int unsigned DIM = tpu_pkg::DIM,
    parameter int unsigned KW  = $clog2(3 * DIM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic                    mac_en,
    output logic                    mac_wren,
    output logic [KW-1:0]           k_idx,
    output logic [DIM-1:0]          a_lane_vld,
    output logic [DIM-1:0]          b_lane_vld,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [$clog2(DIM)-1:0]  rd_row
);

    import tpu_pkg::*;

    localparam int unsigned RW = $clog2(DIM);
    localparam logic [KW-1:0] KLast   = KW'(3 * DIM - 3);
    localparam logic [RW-1:0] RowLast = RW'(DIM - 1);

    tpu_seq_state_t  state_q;
    logic [KW-1:0]   k_q;
    logic [RW-1:0]   row_q;
    logic [DIM-1:0]  lane_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            row_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_q <= StClear;
                end
                StClear: begin
                    state_q <= StCompute;
                    k_q     <= '0;
                end
                StCompute: begin
                    if (!stall) begin
                        // k_idx saturates on the last feed step instead of wrapping
                        if (k_q == KLast) begin
                            state_q <= StDrain;
                            row_q   <= '0;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (rd_ready) begin
                        if (row_q == RowLast) state_q <= StDone;
                        else                  row_q   <= row_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    k_q     <= '0;
                    row_q   <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    tpu_skew_decode #(
        .DIM (DIM),
        .KW  (KW)
    ) u_skew (
        .k_idx  (k_q),
        .active (state_q == StCompute),
        .mask   (lane_vld)
    );

    // mac_en is the only output with a combinational input path (from stall)
    assign mac_en     = (state_q == StCompute) && !stall;
    assign mac_wren   = (state_q == StClear);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign rd_valid   = (state_q == StDrain);
    assign k_idx      = k_q;
    assign rd_row     = row_q;
    assign a_lane_vld = lane_vld;
    assign b_lane_vld = lane_vld;

endmodule

// File: tb/tb_tpu_seq.sv
// Bench for tpu_seq (DIM=4): event-count model checked every cycle plus directed scenarios.
module tb_tpu_seq;

    localparam int DIM = 4;
    localparam int KW  = $clog2(3 * DIM);
    localparam int NEN = 3 * DIM - 2;
    localparam int KL  = 3 * DIM - 3;

    logic                   clk = 1'b0;
    logic                   rst, start, stall, rd_ready;
    logic                   busy, done, mac_en, mac_wren, rd_valid;
    logic [KW-1:0]          k_idx;
    logic [DIM-1:0]         a_lane_vld, b_lane_vld;
    logic [$clog2(DIM)-1:0] rd_row;

    always #5 clk = ~clk;

    tpu_seq #(
        .DIM (DIM),
        .KW  (KW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .mac_en     (mac_en),
        .mac_wren   (mac_wren),
        .k_idx      (k_idx),
        .a_lane_vld (a_lane_vld),
        .b_lane_vld (b_lane_vld),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_row     (rd_row)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: counts of events in the current run rather than an explicit state.
    bit m_active, m_cleared, m_done;
    int m_en, m_beats;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0; m_cleared <= 1'b0; m_done <= 1'b0;
            m_en <= 0; m_beats <= 0;
        end else if (m_done) begin
            m_done <= 1'b0; m_en <= 0; m_beats <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1; m_cleared <= 1'b0; m_en <= 0; m_beats <= 0;
            end
        end else if (!m_cleared) begin
            m_cleared <= 1'b1;
        end else if (m_en < NEN) begin
            if (!stall) m_en <= m_en + 1;
        end else if (rd_ready) begin
            if (m_beats == DIM - 1) begin
                m_done <= 1'b1; m_active <= 1'b0;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    function automatic int exp_lanes(input int k, input bit comp);
        int m = 0;
        for (int i = 0; i < DIM; i++)
            if (comp && k >= i && k <= i + DIM - 1) m |= (1 << i);
        return m;
    endfunction

    bit cmp_en = 1'b0;

    always @(negedge clk) begin : cmp
        bit comp, drain;
        int k_exp;
        if (cmp_en) begin
            comp  = m_active && m_cleared && (m_en < NEN);
            drain = m_active && m_cleared && (m_en == NEN);
            k_exp = (m_en > KL) ? KL : m_en;
            check("busy",     int'(busy),       int'(m_active || m_done));
            check("done",     int'(done),       int'(m_done));
            check("mac_wren", int'(mac_wren),   int'(m_active && !m_cleared));
            check("mac_en",   int'(mac_en),     int'(comp && !stall));
            check("rd_valid", int'(rd_valid),   int'(drain));
            check("k_idx",    int'(k_idx),      k_exp);
            check("rd_row",   int'(rd_row),     m_beats);
            check("a_lane",   int'(a_lane_vld), exp_lanes(k_exp, comp));
            check("b_lane",   int'(b_lane_vld), exp_lanes(k_exp, comp));
        end
    end

    int r_done_cyc, r_en, r_wren, r_comp, r_row1, r_beats;
    int beat_rows [8];
    bit pat [6];

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_en"},    int'(mac_en), 0);
        check({tag, "_wren"},  int'(mac_wren), 0);
        check({tag, "_rdv"},   int'(rd_valid), 0);
        check({tag, "_k"},     int'(k_idx), 0);
        check({tag, "_row"},   int'(rd_row), 0);
        check({tag, "_alane"}, int'(a_lane_vld), 0);
        check({tag, "_blane"}, int'(b_lane_vld), 0);
    endtask

    // mode 0 plain, 1 stall at k=4, 2 rd_ready pattern, 3 stray starts, 4 reset at k=6
    task automatic run(input int mode);
        int  j, stalls;
        bit  in_comp, rst_done;
        r_done_cyc = -1; r_en = 0; r_wren = 0; r_comp = 0; r_row1 = 0; r_beats = 0;
        j = 0; stalls = 0; rst_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; stall = 1'b0; rst = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 60 && r_done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0; stall = 1'b0; rst = 1'b0; rd_ready = 1'b1;
            in_comp = busy && !mac_wren && !rd_valid && !done;
            if (mode == 1 && in_comp && k_idx == 4 && stalls < 3) begin
                stall = 1'b1; stalls++;
            end
            if (mode == 2 && rd_valid) begin
                rd_ready = (j < 6) ? pat[j] : 1'b1; j++;
            end
            if (mode == 3 && ((in_comp && k_idx == 3) || done)) start = 1'b1;
            if (mode == 4 && in_comp && k_idx == 6 && !rst_done) begin
                rst = 1'b1; rst_done = 1'b1;
            end
            @(negedge clk);
            if (mode == 4 && rst_done && !rst) begin
                check_zero("abort");
                break;
            end
            if (mac_en) r_en++;
            if (mac_wren) r_wren++;
            if (in_comp) r_comp++;
            if (rd_valid && rd_row == 1) r_row1++;
            if (rd_valid && rd_ready) begin
                if (r_beats < 8) beat_rows[r_beats] = int'(rd_row);
                r_beats++;
            end
            if (mode == 0 && in_comp && k_idx == 0) check("lane_k0", int'(a_lane_vld), 1);
            if (mode == 0 && in_comp && k_idx == 5) check("lane_k5", int'(a_lane_vld), 12);
            if (mode == 0 && in_comp && k_idx == 9) check("lane_k9", int'(a_lane_vld), 0);
            if (mode == 1 && stall) begin
                check("stall_k", int'(k_idx), 4);
                check("stall_en", int'(mac_en), 0);
            end
            if (done) r_done_cyc = cyc;
        end
        @(posedge clk); #1;
        start = 1'b0; stall = 1'b0; rst = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
        check("idle_after_busy", int'(busy), 0);
    endtask

    task automatic check_plain(input string tag);
        check({tag, "_done_cyc"}, r_done_cyc, 16);
        check({tag, "_en_cnt"},   r_en, 10);
        check({tag, "_wren_cnt"}, r_wren, 1);
        check({tag, "_comp_cyc"}, r_comp, 10);
        check({tag, "_beats"},    r_beats, 4);
        for (int i = 0; i < 4; i++) check({tag, "_beat_row"}, beat_rows[i], i);
    endtask

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        // reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1; stall = 1'b0; rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        run(0);
        check_plain("basic");

        run(1);
        check("stall_done_cyc", r_done_cyc, 19);
        check("stall_en_cnt",   r_en, 10);
        check("stall_comp_cyc", r_comp, 13);
        check("stall_beats",    r_beats, 4);

        run(2);
        check("rdy_done_cyc", r_done_cyc, 18);
        check("rdy_row1_cyc", r_row1, 3);
        check("rdy_beats",    r_beats, 4);
        for (int i = 0; i < 4; i++) check("rdy_beat_row", beat_rows[i], i);

        run(3);
        check("ign_done_cyc", r_done_cyc, 16);
        check("ign_en_cnt",   r_en, 10);

        run(4);
        check("abort_no_done", r_done_cyc, -1);

        run(0);
        check_plain("rerun");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
